uart_rx_param: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Adds configurable data width,

---
 rtl/uart_rx_param.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with configurable data width (LSB first), optional
// odd/even parity and one or two stop bits. Every bit is sampled three times
// around its centre and decided by majority vote. A start bit whose majority
// reads high is rejected as a glitch.
//
// Parameters
//   CLOCK_HZ   system clock frequency in Hz
//   BAUD       line rate; TICKS = CLOCK_HZ/BAUD clocks per bit (>= 8)
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous active-low reset
//   Rx_i           in   serial line, idle high, asynchronous to Clock
//   Data_o         out  last received word, held until the next Done_o
//   Done_o         out  one-cycle pulse, frame complete and Data_o/flags valid
//   ParityError_o  out  parity mismatch on the last frame (0 without parity)
//   FrameError_o   out  any stop bit of the last frame sampled low
//   Busy_o         out  high from start-edge detection until back in IDLE
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLOCK_HZ  = 1_000_000,
    parameter int BAUD      = 100_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rx_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 Done_o,
    output logic                 ParityError_o,
    output logic                 FrameError_o,
    output logic                 Busy_o
);

    localparam int TICKS = CLOCK_HZ / BAUD;
    localparam int MID   = TICKS / 2;
    localparam int TW    = $clog2(TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(MID - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(MID);
    localparam logic [TW-1:0] TICK_DEC  = TW'(MID + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    // XOR of data and parity bit that a correct frame produces
    localparam logic          PAR_GOOD  = (PARITY == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Majority of three samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even-parity reduction of the received data word
    function automatic logic parityOf(input logic [DATA_BITS-1:0] v);
        return ^v;
    endfunction

    state_t                 state_r;
    state_t                 nextState_s;
    logic                   rxMeta_r;
    logic                   rxS_r;
    logic                   rxPrev_r;
    logic [TW-1:0]          tickCnt_r;
    logic [3:0]             bitCnt_r;
    logic                   samp0_r;
    logic                   samp1_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   parErrAcc_r;
    logic                   frameErrAcc_r;
    logic [DATA_BITS-1:0]   dataOut_r;
    logic                   done_r;
    logic                   parErrOut_r;
    logic                   frameErrOut_r;
    logic                   busy_r;

    logic                   fallEdge_s;
    logic                   atDecide_s;
    logic                   atBitEnd_s;
    logic                   bitVal_s;

    assign fallEdge_s = rxPrev_r & ~rxS_r;
    assign atDecide_s = (tickCnt_r == TICK_DEC);
    assign atBitEnd_s = (tickCnt_r == TICK_LAST);
    // Third sample is the live synchronised line at the decision tick
    assign bitVal_s   = majority3(samp0_r, samp1_r, rxS_r);

    assign Data_o        = dataOut_r;
    assign Done_o        = done_r;
    assign ParityError_o = parErrOut_r;
    assign FrameError_o  = frameErrOut_r;
    assign Busy_o        = busy_r;

    // Two-flop synchroniser plus previous-value flop for falling-edge detection
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rxMeta_r <= 1'b1;
            rxS_r    <= 1'b1;
            rxPrev_r <= 1'b1;
        end else begin
            rxMeta_r <= Rx_i;
            rxS_r    <= rxMeta_r;
            rxPrev_r <= rxS_r;
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; the last stop bit exits at its decision tick so a
    // start edge immediately following the stop bit is still caught
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fallEdge_s) nextState_s = S_START;
                else            nextState_s = S_IDLE;
            end
            S_START: begin
                if (atDecide_s && bitVal_s) nextState_s = S_IDLE;
                else if (atBitEnd_s)        nextState_s = S_DATA;
                else                        nextState_s = S_START;
            end
            S_DATA: begin
                if (atBitEnd_s && (bitCnt_r == DATA_LAST))
                    nextState_s = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                    nextState_s = S_DATA;
            end
            S_PARITY: begin
                if (atBitEnd_s) nextState_s = S_STOP;
                else            nextState_s = S_PARITY;
            end
            S_STOP: begin
                if (atDecide_s && (bitCnt_r == STOP_LAST)) nextState_s = S_DONE;
                else                                       nextState_s = S_STOP;
            end
            S_DONE:  nextState_s = S_IDLE;
            default: nextState_s = S_IDLE;
        endcase
    end

    // Bit timing: tick counter restarts on every bit and on every state change
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tickCnt_r <= '0;
            bitCnt_r  <= 4'd0;
        end else begin
            if ((state_r == S_IDLE) || (nextState_s != state_r) || atBitEnd_s)
                tickCnt_r <= '0;
            else
                tickCnt_r <= tickCnt_r + TW'(1);

            if (nextState_s != state_r)
                bitCnt_r <= 4'd0;
            else if (atBitEnd_s && ((state_r == S_DATA) || (state_r == S_STOP)))
                bitCnt_r <= bitCnt_r + 4'd1;
        end
    end

    // Sample capture, data shifting and per-frame error accumulation
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            samp0_r       <= 1'b1;
            samp1_r       <= 1'b1;
            shift_r       <= '0;
            parErrAcc_r   <= 1'b0;
            frameErrAcc_r <= 1'b0;
        end else begin
            if (tickCnt_r == TICK_S0) samp0_r <= rxS_r;
            if (tickCnt_r == TICK_S1) samp1_r <= rxS_r;

            if ((state_r == S_IDLE) && fallEdge_s) begin
                parErrAcc_r   <= 1'b0;
                frameErrAcc_r <= 1'b0;
            end

            if ((state_r == S_DATA) && atDecide_s)
                shift_r <= {bitVal_s, shift_r[DATA_BITS-1:1]};

            if ((state_r == S_PARITY) && atDecide_s)
                parErrAcc_r <= ((parityOf(shift_r) ^ bitVal_s) != PAR_GOOD);

            if ((state_r == S_STOP) && atDecide_s && !bitVal_s)
                frameErrAcc_r <= 1'b1;
        end
    end

    // Registered outputs; word and flags load together with the Done pulse
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dataOut_r     <= '0;
            done_r        <= 1'b0;
            parErrOut_r   <= 1'b0;
            frameErrOut_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            done_r <= (nextState_s == S_DONE);
            busy_r <= (nextState_s != S_IDLE);
            if (nextState_s == S_DONE) begin
                dataOut_r     <= shift_r;
                parErrOut_r   <= (PARITY != 0) ? parErrAcc_r : 1'b0;
                // Include the stop bit being decided right now
                frameErrOut_r <= frameErrAcc_r | ~bitVal_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param. Three instances cover 8N1, 8E1 and 7O2.
// Frames are bit-banged at 10 clocks per bit; every expected value is written
// out by hand next to the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    logic       Clock;
    logic       Reset;
    logic       rx0, rx1, rx2;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic       done0, done1, done2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       busy0, busy1, busy2;

    int totalCnt = 0;
    int badCnt   = 0;
    int doneCnt0 = 0;
    int cntSave  = 0;

    uart_rx_param u8n1 (
        .Clock(Clock), .Reset(Reset), .Rx_i(rx0), .Data_o(data0), .Done_o(done0),
        .ParityError_o(pe0), .FrameError_o(fe0), .Busy_o(busy0)
    );

    uart_rx_param #(.PARITY(2)) u8e1 (
        .Clock(Clock), .Reset(Reset), .Rx_i(rx1), .Data_o(data1), .Done_o(done1),
        .ParityError_o(pe1), .FrameError_o(fe1), .Busy_o(busy1)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u7o2 (
        .Clock(Clock), .Reset(Reset), .Rx_i(rx2), .Data_o(data2), .Done_o(done2),
        .ParityError_o(pe2), .FrameError_o(fe2), .Busy_o(busy2)
    );

    // 100 MHz-style clock, period 10
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Count Done pulses of the 8N1 instance away from the active edge
    always @(negedge Clock) begin
        if (done0) doneCnt0 <= doneCnt0 + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic driveBit(input int which, input logic b);
        case (which)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
        waitClk(10);
    endtask

    // Start bit, data LSB first, optional parity bit, stop bits (stopVals[0] first).
    // Returns 1 clock after the decision tick of the last stop bit is evaluated.
    task automatic sendFrame(input int which, input logic [8:0] data, input int nData,
                             input int hasPar, input logic parBit,
                             input int nStop, input logic [1:0] stopVals);
        driveBit(which, 1'b0);
        for (int i = 0; i < nData; i++) driveBit(which, data[i]);
        if (hasPar != 0) driveBit(which, parBit);
        for (int i = 0; i < nStop; i++) driveBit(which, stopVals[i]);
    endtask

    initial begin
        Reset = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        waitClk(3);
        checkVal("rst data0", 32'(data0), 32'h0);
        checkVal("rst done0", 32'(done0), 32'h0);
        checkVal("rst busy0", 32'(busy0), 32'h0);
        checkVal("rst pe0",   32'(pe0),   32'h0);
        checkVal("rst fe0",   32'(fe0),   32'h0);
        checkVal("rst busy1", 32'(busy1), 32'h0);
        checkVal("rst fe1",   32'(fe1),   32'h0);
        checkVal("rst busy2", 32'(busy2), 32'h0);
        Reset = 1'b1;
        waitClk(5);

        // 8N1 back-to-back 0x55 then 0xAA
        cntSave = doneCnt0;
        sendFrame(0, 9'h055, 8, 0, 1'b0, 1, 2'b11);
        checkVal("t1 done a", 32'(done0), 32'h1);
        checkVal("t1 data a", 32'(data0), 32'h55);
        checkVal("t1 busy in done", 32'(busy0), 32'h1);
        sendFrame(0, 9'h0AA, 8, 0, 1'b0, 1, 2'b11);
        checkVal("t1 done b", 32'(done0), 32'h1);
        checkVal("t1 data b", 32'(data0), 32'hAA);
        checkVal("t1 pe",     32'(pe0),   32'h0);
        checkVal("t1 fe",     32'(fe0),   32'h0);
        waitClk(1);
        checkVal("t1 done pulse", 32'(done0), 32'h0);
        checkVal("t1 busy after", 32'(busy0), 32'h0);
        checkVal("t1 done count", 32'(doneCnt0), 32'(cntSave + 2));

        // Even parity: 0x53 has four ones, correct parity bit is 0
        sendFrame(1, 9'h053, 8, 1, 1'b0, 1, 2'b11);
        checkVal("t2 done good", 32'(done1), 32'h1);
        checkVal("t2 data good", 32'(data1), 32'h53);
        checkVal("t2 pe good",   32'(pe1),   32'h0);
        waitClk(1);
        checkVal("t2 done low",  32'(done1), 32'h0);
        sendFrame(1, 9'h053, 8, 1, 1'b1, 1, 2'b11);
        checkVal("t2 done bad",  32'(done1), 32'h1);
        checkVal("t2 data bad",  32'(data1), 32'h53);
        checkVal("t2 pe bad",    32'(pe1),   32'h1);
        checkVal("t2 fe",        32'(fe1),   32'h0);

        // Stop bit low on 0xC3, then a clean 0x81 clears the flag
        waitClk(5);
        sendFrame(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b00);
        checkVal("t3 done", 32'(done0), 32'h1);
        checkVal("t3 data", 32'(data0), 32'hC3);
        checkVal("t3 fe",   32'(fe0),   32'h1);
        checkVal("t3 pe",   32'(pe0),   32'h0);
        rx0 = 1'b1;
        waitClk(20);
        checkVal("t3 fe held", 32'(fe0), 32'h1);
        sendFrame(0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
        checkVal("t3 data next", 32'(data0), 32'h81);
        checkVal("t3 fe clear",  32'(fe0),   32'h0);

        // Glitch: 3 clocks low is rejected as a false start
        waitClk(5);
        cntSave = doneCnt0;
        rx0 = 1'b0;
        waitClk(3);
        rx0 = 1'b1;
        checkVal("t4 busy up", 32'(busy0), 32'h1);
        waitClk(10);
        checkVal("t4 busy down", 32'(busy0), 32'h0);
        checkVal("t4 no done",   32'(doneCnt0), 32'(cntSave));
        checkVal("t4 data kept", 32'(data0), 32'h81);

        // Reset mid-data of 0x0F (first four data bits are ones)
        waitClk(5);
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, 1'b1);
        checkVal("t5 busy mid", 32'(busy0), 32'h1);
        Reset = 1'b0;
        rx0   = 1'b1;
        #1;
        checkVal("t5 rst data0", 32'(data0), 32'h0);
        checkVal("t5 rst busy0", 32'(busy0), 32'h0);
        checkVal("t5 rst done0", 32'(done0), 32'h0);
        checkVal("t5 rst pe1",   32'(pe1),   32'h0);
        checkVal("t5 rst data1", 32'(data1), 32'h0);
        waitClk(2);
        cntSave = doneCnt0;
        Reset = 1'b1;
        waitClk(150);
        checkVal("t5 no done after", 32'(doneCnt0), 32'(cntSave));
        sendFrame(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
        checkVal("t5 done", 32'(done0), 32'h1);
        checkVal("t5 data", 32'(data0), 32'h3C);
        checkVal("t5 fe",   32'(fe0),   32'h0);

        // 7 data, odd parity, 2 stops: 0x5A has four ones, odd parity bit is 1
        sendFrame(2, 9'h05A, 7, 1, 1'b1, 2, 2'b11);
        checkVal("t6 done", 32'(done2), 32'h1);
        checkVal("t6 data", 32'(data2), 32'h5A);
        checkVal("t6 pe",   32'(pe2),   32'h0);
        checkVal("t6 fe",   32'(fe2),   32'h0);
        waitClk(5);
        sendFrame(2, 9'h05A, 7, 1, 1'b1, 2, 2'b01);
        checkVal("t6 done 2nd", 32'(done2), 32'h1);
        checkVal("t6 data 2nd", 32'(data2), 32'h5A);
        checkVal("t6 fe 2nd",   32'(fe2),   32'h1);
        checkVal("t6 pe 2nd",   32'(pe2),   32'h0);
        rx2 = 1'b1;
        waitClk(5);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
